cond_branch_unit: RTL and testbench

Parametrised, pipelined successor to the combinational condition handler. It computes its own WIDTH-bit compare/add flags, evaluates the 3-bit PA-RISC condition with optional negation, and registers the jump decision. It also runs the delay-slot nullification state machine and keeps a saturating taken-branch counter. It sits between the execute-stage operand muxes and the fetch/PC-select logic.

---
 rtl/cond_branch_unit.sv | 118 +++++++++++
 tb/tb_cond_branch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_branch_unit.sv
// Conditional branch unit: computes compare/add flags, evaluates the PA-RISC condition,
// registers the jump decision, tracks delay-slot nullification and counts taken branches.
module cond_branch_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_valid,
    input  logic             op_add,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       cond,
    input  logic             neg_cond,
    input  logic             nul,
    input  logic             disp_neg,
    input  logic             slot_valid,
    output logic             j_valid,
    output logic             j,
    output logic             nullify,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    logic               jv_q, jv_d;
    logic               j_q, j_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   b_op;
    logic [WIDTH:0]     sum;
    logic               flag_z, flag_n, flag_v, flag_c, flag_odd;
    logic               eval_c, taken_c, accept_c, fire_c, slot_killed_c;

    // Subtraction is a + ~b + 1, so one adder serves both operations.
    assign b_op     = op_add ? b : ~b;
    assign sum      = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, ~op_add};

    assign flag_z   = (sum[WIDTH-1:0] == '0);
    assign flag_n   = sum[WIDTH-1];
    assign flag_odd = sum[0];
    assign flag_v   = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    // Carry-out of a + ~b + 1 is the inverse of the unsigned borrow.
    assign flag_c   = op_add ? sum[WIDTH] : ~sum[WIDTH];

    always_comb begin
        eval_c = 1'b0;
        unique case (cond)
            3'b000:  eval_c = 1'b0;
            3'b001:  eval_c = flag_z;
            3'b010:  eval_c = flag_n ^ flag_v;
            3'b011:  eval_c = flag_z | (flag_n ^ flag_v);
            3'b100:  eval_c = flag_c;
            3'b101:  eval_c = flag_z | flag_c;
            3'b110:  eval_c = flag_v;
            default: eval_c = flag_odd;
        endcase
    end

    assign taken_c       = eval_c ^ neg_cond;
    assign slot_killed_c = (state_q == PEND) && slot_valid;
    assign accept_c      = br_valid && !slot_killed_c;
    assign fire_c        = nul && (disp_neg ? !taken_c : taken_c);
    assign nullify       = slot_killed_c;

    // Next-state: flush beats stall; stall freezes everything else.
    always_comb begin
        state_d = state_q;
        jv_d    = jv_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        if (flush) begin
            jv_d    = 1'b0;
            state_d = IDLE;
        end else if (!stall) begin
            jv_d = accept_c;
            if (slot_killed_c) begin
                state_d = IDLE;
            end
            if (accept_c) begin
                j_d = taken_c;
                if (taken_c && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (fire_c) begin
                    state_d = PEND;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            jv_q    <= 1'b0;
            j_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            jv_q    <= jv_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
        end
    end

    assign j_valid   = jv_q;
    assign j         = j_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_cond_branch_unit.sv
// Bench for cond_branch_unit: directed test-plan cases then random traffic against an
// arithmetic reference model; a second instance with a 2-bit counter checks saturation.
module tb_cond_branch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, flush, br_valid, op_add, neg_cond, nul, disp_neg, slot_valid;
    logic [31:0] a, b;
    logic [2:0]  cond;
    logic        j_valid, j, nullify;
    logic [15:0] taken_cnt;
    logic        j_valid2, j2, nullify2;
    logic [1:0]  taken_cnt2;

    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model state
    bit          m_pend, m_jv, m_j;
    int          m_cnt, m_cnt2, c0;

    always #5 clk = ~clk;

    cond_branch_unit #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .br_valid(br_valid),
        .op_add(op_add), .a(a), .b(b), .cond(cond), .neg_cond(neg_cond), .nul(nul),
        .disp_neg(disp_neg), .slot_valid(slot_valid), .j_valid(j_valid), .j(j),
        .nullify(nullify), .taken_cnt(taken_cnt)
    );

    cond_branch_unit #(.WIDTH(32), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .br_valid(br_valid),
        .op_add(op_add), .a(a), .b(b), .cond(cond), .neg_cond(neg_cond), .nul(nul),
        .disp_neg(disp_neg), .slot_valid(slot_valid), .j_valid(j_valid2), .j(j2),
        .nullify(nullify2), .taken_cnt(taken_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // Condition evaluated from integer arithmetic on the operands.
    function automatic bit eval_cond(bit add, logic [31:0] x, logic [31:0] y, logic [2:0] c);
        longint ux, uy, sx, sy, ur, sr;
        logic [31:0] res;
        bit z, n, v, cf, odd;
        ux  = longint'(x);
        uy  = longint'(y);
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ur  = add ? ux + uy : ux - uy;
        sr  = add ? sx + sy : sx - sy;
        res = ur[31:0];
        z   = (res == 32'd0);
        n   = res[31];
        odd = res[0];
        v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        cf  = add ? (ur > 64'hFFFF_FFFF) : (ux < uy);
        case (c)
            3'd0:    return 1'b0;
            3'd1:    return z;
            3'd2:    return n ^ v;
            3'd3:    return z | (n ^ v);
            3'd4:    return cf;
            3'd5:    return z | cf;
            3'd6:    return v;
            default: return odd;
        endcase
    endfunction

    task automatic clear_inputs();
        stall = 0; flush = 0; br_valid = 0; op_add = 0; neg_cond = 0; nul = 0;
        disp_neg = 0; slot_valid = 0; a = 0; b = 0; cond = 0;
    endtask

    task automatic model_reset();
        m_pend = 0; m_jv = 0; m_j = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    // One clock: check nullify before the edge, advance model on the edge, check after.
    task automatic cycle();
        bit t, acc, kill;
        #1;
        chk("nullify", nullify, 32'(m_pend & slot_valid));
        chk("nullify2", nullify2, 32'(m_pend & slot_valid));
        @(posedge clk);
        if (flush) begin
            m_jv = 0;
            m_pend = 0;
        end else if (!stall) begin
            t    = eval_cond(op_add, a, b, cond) ^ neg_cond;
            kill = m_pend && slot_valid;
            acc  = br_valid && !kill;
            m_jv = acc;
            if (kill) m_pend = 0;
            if (acc) begin
                m_j = t;
                if (t) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
                if (nul && (disp_neg ? !t : t)) m_pend = 1;
            end
        end
        #1;
        chk("j_valid", j_valid, 32'(m_jv));
        chk("j", j, 32'(m_j));
        chk("taken_cnt", taken_cnt, 32'(m_cnt));
        chk("j_valid2", j_valid2, 32'(m_jv));
        chk("taken_cnt2", taken_cnt2, 32'(m_cnt2));
    endtask

    task automatic branch(input bit add, input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] c, input bit ng, input bit nl, input bit dn);
        clear_inputs();
        br_valid = 1; op_add = add; a = x; b = y; cond = c; neg_cond = ng; nul = nl; disp_neg = dn;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 7));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        clear_inputs();
        model_reset();
        reset_n = 0;
        #3;
        chk("rst_j_valid", j_valid, 0);
        chk("rst_j", j, 0);
        chk("rst_nullify", nullify, 0);
        chk("rst_taken_cnt", taken_cnt, 0);
        @(negedge clk);
        reset_n = 1;

        // Equal operands, Z condition, then negated
        branch(0, 5, 5, 3'b001, 0, 0, 0); cycle();
        chk("eq_j", j, 1); chk("eq_cnt", taken_cnt, 1);
        branch(0, 5, 5, 3'b001, 1, 0, 0); cycle();
        chk("eq_neg_j", j, 0); chk("eq_neg_cnt", taken_cnt, 1);

        // Unsigned vs signed compare, add overflow
        branch(0, 32'hFFFF_FFFF, 1, 3'b100, 0, 0, 0); cycle(); chk("uns_lt_j", j, 0);
        branch(0, 32'hFFFF_FFFF, 1, 3'b010, 0, 0, 0); cycle(); chk("sgn_lt_j", j, 1);
        branch(1, 32'h7FFF_FFFF, 1, 3'b110, 0, 0, 0); cycle(); chk("add_ovf_j", j, 1);

        // Forward taken nul branch nullifies the next slot once
        branch(0, 5, 5, 3'b001, 0, 1, 0); cycle();
        clear_inputs(); slot_valid = 1; #1; chk("fwd_nullify", nullify, 1); cycle();
        chk("fwd_idle", nullify, 0); cycle();

        // Backward: not taken nullifies, taken does not
        branch(0, 5, 5, 3'b000, 0, 1, 1); cycle();
        clear_inputs(); slot_valid = 1; cycle();
        branch(0, 5, 5, 3'b001, 0, 1, 1); cycle();
        clear_inputs(); slot_valid = 1; #1; chk("bwd_taken_nullify", nullify, 0); cycle();

        // Branch in nullified slot is ignored
        c0 = m_cnt;
        branch(0, 5, 5, 3'b001, 0, 1, 0); cycle();
        branch(0, 7, 7, 3'b001, 0, 0, 0); slot_valid = 1; cycle();
        chk("killed_jv", j_valid, 0); chk("killed_cnt", taken_cnt, 32'(c0 + 1));

        // Stall holds PEND with nullify asserted
        branch(0, 5, 5, 3'b001, 0, 1, 0); cycle();
        clear_inputs(); slot_valid = 1; stall = 1; cycle(); cycle();
        chk("stall_nullify", nullify, 1);
        stall = 0; cycle(); chk("unstall_nullify", nullify, 0);

        // Flush drops a sampled branch and clears PEND
        branch(0, 5, 5, 3'b001, 0, 1, 0); cycle();
        branch(0, 5, 5, 3'b001, 0, 1, 0); flush = 1; cycle();
        chk("flush_jv", j_valid, 0);
        clear_inputs(); slot_valid = 1; #1; chk("flush_nullify", nullify, 0); cycle();
        chk("sat_cnt2", taken_cnt2, 3);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            clear_inputs();
            br_valid   = ($urandom_range(0, 3) != 0);
            op_add     = 1'($urandom_range(0, 1));
            a          = pick();
            b          = ($urandom_range(0, 5) == 0) ? a : pick();
            cond       = 3'($urandom_range(0, 7));
            neg_cond   = 1'($urandom_range(0, 1));
            nul        = 1'($urandom_range(0, 1));
            disp_neg   = 1'($urandom_range(0, 1));
            slot_valid = 1'($urandom_range(0, 1));
            stall      = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            cycle();
        end

        // Asynchronous reset between edges
        branch(0, 5, 5, 3'b001, 0, 1, 0); cycle();
        clear_inputs(); slot_valid = 1;
        #2 reset_n = 0;
        #1;
        chk("arst_j_valid", j_valid, 0);
        chk("arst_j", j, 0);
        chk("arst_nullify", nullify, 0);
        chk("arst_taken_cnt", taken_cnt, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        branch(0, 3, 3, 3'b001, 0, 0, 0); cycle();
        clear_inputs(); cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
